// File: rtl/fetch_stage_if.sv
// fetch_stage_if: iCache refill handshake between the fetch stage and memory.
//   mem_req   fetch -> mem   refill request, held until mem_ready
//   mem_addr  fetch -> mem   refill address (latched miss PC), stable while mem_req
//   mem_ready mem -> fetch   refill done; line is now resident in the iCache
interface fetch_stage_if #(
  parameter int ADDR_W = 32
);
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ready;

  modport master (output mem_req, output mem_addr, input mem_ready);
  modport slave  (input mem_req, input mem_addr, output mem_ready);
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: IF stage. Owns the PC, runs the iTLB/iCache lookup and drives
// the IF-ID bank. iCache misses are serialised as refills over the mem
// handshake; an iTLB miss parks the stage until an exception or redirect.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   stall_ID          ID hazard stall; holds the IF-ID bank
//   redirect_valid/pc taken branch/jump target (low two bits ignored)
//   exc_valid         exception taken; fetch restarts at EXC_VECTOR
//   itlb_hit          combinational iTLB hit for pc
//   icache_hit/data   combinational iCache hit and word for pc
//   mem               refill handshake (master side)
//   pc                lookup address to iTLB/iCache
//   instruction_IF, PC_IF, iTLB_hit_IF, load_IF_ID, bubble_IF_ID  IF-ID bank
//
// state  | meaning
// RUN    | normal lookup of pc every cycle
// REFILL | iCache miss outstanding; mem_req held until mem_ready
// FAULT  | iTLB miss delivered; waiting for exception or redirect
module fetch_stage #(
  parameter int              ADDR_W     = 32,
  parameter int              INSTR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_PC   = 32'h0000_1000,
  parameter logic [ADDR_W-1:0] EXC_VECTOR = 32'h0000_2000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall_ID,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  input  logic               exc_valid,
  input  logic               itlb_hit,
  input  logic               icache_hit,
  input  logic [INSTR_W-1:0] icache_data,
  fetch_stage_if.master      mem,
  output logic [ADDR_W-1:0]  pc,
  output logic [INSTR_W-1:0] instruction_IF,
  output logic [ADDR_W-1:0]  PC_IF,
  output logic               iTLB_hit_IF,
  output logic               load_IF_ID,
  output logic               bubble_IF_ID
);

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_REFILL = 2'd1,
    S_FAULT  = 2'd2
  } state_e;

  localparam logic [ADDR_W-1:0] PC_STEP    = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] miss_addr_q, miss_addr_d;
  logic              mem_req_q, mem_req_d;
  logic              flush;
  logic              lookup_hit;

  assign flush      = exc_valid | redirect_valid;
  assign lookup_hit = itlb_hit & icache_hit;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_RUN;
      pc_q        <= RESET_PC;
      miss_addr_q <= '0;
      mem_req_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      miss_addr_q <= miss_addr_d;
      mem_req_q   <= mem_req_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    miss_addr_d = miss_addr_q;
    mem_req_d   = mem_req_q;

    // A flush always retargets the PC, even mid-refill.
    if (exc_valid) begin
      pc_d = EXC_VECTOR;
    end else if (redirect_valid) begin
      pc_d = redirect_pc & ALIGN_MASK;
    end

    case (state_q)
      S_REFILL: begin
        // The outstanding refill must complete before fetch resumes,
        // regardless of any flush seen meanwhile.
        if (mem.mem_ready) begin
          state_d   = S_RUN;
          mem_req_d = 1'b0;
        end
      end
      S_RUN: begin
        if (!flush) begin
          if (lookup_hit) begin
            if (!stall_ID) pc_d = pc_q + PC_STEP;
          end else if (itlb_hit) begin
            state_d     = S_REFILL;
            miss_addr_d = pc_q;
            mem_req_d   = 1'b1;
          end else if (!stall_ID) begin
            state_d = S_FAULT;
          end
        end
      end
      S_FAULT: begin
        if (flush) state_d = S_RUN;
      end
      default: state_d = S_RUN;
    endcase
  end

  always_comb begin
    load_IF_ID     = 1'b0;
    bubble_IF_ID   = 1'b0;
    instruction_IF = '0;
    iTLB_hit_IF    = 1'b0;

    if (reset) begin
      bubble_IF_ID = 1'b1;
    end else begin
      if (state_q == S_RUN) begin
        iTLB_hit_IF = itlb_hit;
        if (lookup_hit) instruction_IF = icache_data;
      end

      if (flush) begin
        bubble_IF_ID = 1'b1;
      end else begin
        case (state_q)
          S_RUN: begin
            if (lookup_hit) begin
              load_IF_ID = !stall_ID;
            end else if (itlb_hit) begin
              bubble_IF_ID = !stall_ID;
            end else begin
              // iTLB miss is passed down once so ID can raise the fault.
              load_IF_ID = !stall_ID;
            end
          end
          S_REFILL, S_FAULT: bubble_IF_ID = !stall_ID;
          default: bubble_IF_ID = 1'b1;
        endcase
      end
    end
  end

  assign pc           = pc_q;
  assign PC_IF        = pc_q;
  assign mem.mem_req  = mem_req_q;
  assign mem.mem_addr = miss_addr_q;

endmodule
